// File: rtl/spi_rd_master.sv
// spi_rd_master: host-side mode-0 SPI read controller.
// Each transaction: flush pulse (cs_n high), 5-bit address MSB-first, 16 data bits in from sdo.
module spi_rd_master #(
    parameter int unsigned CLK_DIV = 4  // sck half-period in clk cycles, must be >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  addr_i,
    output logic        busy,
    output logic        done,
    output logic [15:0] data_o,
    output logic        err_o,
    output logic        sck,
    output logic        cs_n,
    output logic        sdi,
    input  logic        sdo,
    input  logic        err_flag_i
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [4:0]      k_q, k_d;
    logic [4:0]      addr_q, addr_d;
    logic [15:0]     shreg_q, shreg_d;
    logic            err_cap_q, err_cap_d;
    logic            sck_q, sck_d;
    logic            cs_n_q, cs_n_d;
    logic            sdi_q, sdi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [15:0]     data_q, data_d;
    logic            err_q, err_d;
    logic            wrap;

    // Every divider wrap is an sck half-period boundary.
    assign wrap = (div_q == DivMax);

    // Next-state logic: phase sequencing, sck/sdi generation and sdo capture.
    always_comb begin
        state_d   = state_q;
        div_d     = wrap ? '0 : div_q + 1'b1;
        k_d       = k_q;
        addr_d    = addr_q;
        shreg_d   = shreg_q;
        err_cap_d = err_cap_q;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        sdi_d     = sdi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        data_d    = data_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                div_d = '0;
                k_d   = '0;
                if (start) begin
                    // Accept edge also launches the flush rising edge.
                    addr_d  = addr_i;
                    state_d = StFlush;
                    busy_d  = 1'b1;
                    sck_d   = 1'b1;
                end
            end
            StFlush: begin
                if (wrap) begin
                    if (sck_q) begin
                        sck_d = 1'b0;
                    end else begin
                        state_d = StSetup;
                        cs_n_d  = 1'b0;
                    end
                end
            end
            StSetup: begin
                if (wrap) begin
                    state_d = StShift;
                    sck_d   = 1'b1;
                    k_d     = 5'd1;
                end
            end
            StShift: begin
                if (wrap) begin
                    if (sck_q) begin
                        // Falling edge: present the address bit for the next rising edge.
                        sck_d = 1'b0;
                        case (k_q)
                            5'd1:    sdi_d = addr_q[4];
                            5'd2:    sdi_d = addr_q[3];
                            5'd3:    sdi_d = addr_q[2];
                            5'd4:    sdi_d = addr_q[1];
                            5'd5:    sdi_d = addr_q[0];
                            default: sdi_d = 1'b0;
                        endcase
                    end else if (k_q == 5'd24) begin
                        state_d = StHold;
                    end else begin
                        // Rising edge k_q+1: sample what the slave presented before it.
                        sck_d = 1'b1;
                        k_d   = k_q + 5'd1;
                        if (k_q >= 5'd8) begin
                            shreg_d = {shreg_q[14:0], sdo};
                        end
                        if (k_q == 5'd23) begin
                            err_cap_d = err_flag_i;
                        end
                    end
                end
            end
            StHold: begin
                if (wrap) begin
                    state_d = StDone;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    data_d  = shreg_q;
                    err_d   = err_cap_q;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                k_d     = '0;
                div_d   = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= '0;
            k_q       <= '0;
            addr_q    <= '0;
            shreg_q   <= '0;
            err_cap_q <= 1'b0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            sdi_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            k_q       <= k_d;
            addr_q    <= addr_d;
            shreg_q   <= shreg_d;
            err_cap_q <= err_cap_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            sdi_q     <= sdi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign data_o = data_q;
    assign err_o  = err_q;
    assign sck    = sck_q;
    assign cs_n   = cs_n_q;
    assign sdi    = sdi_q;

endmodule

// File: tb/tb_spi_rd_master.sv
// tb_spi_rd_master: two DUTs (CLK_DIV=4 and CLK_DIV=2), each with a behavioural SPI slave + ROM.
module tb_spi_rd_master;

    localparam int D4 = 4;
    localparam int D2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0, start2 = 1'b0;
    logic [4:0] addr4 = '0, addr2 = '0;
    logic busy4, done4, err4, sck4, cs_n4, sdi4;
    logic busy2, done2, err2, sck2, cs_n2, sdi2;
    logic [15:0] data4, data2;
    logic sdo4 = 1'b0, ef4 = 1'b0, sdo2 = 1'b0, ef2 = 1'b0;

    logic [15:0] mem [32];
    logic alarm = 1'b0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    spi_rd_master #(.CLK_DIV(D4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .addr_i(addr4), .busy(busy4), .done(done4),
        .data_o(data4), .err_o(err4), .sck(sck4), .cs_n(cs_n4), .sdi(sdi4), .sdo(sdo4),
        .err_flag_i(ef4)
    );

    spi_rd_master #(.CLK_DIV(D2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .addr_i(addr2), .busy(busy2), .done(done2),
        .data_o(data2), .err_o(err2), .sck(sck2), .cs_n(cs_n2), .sdi(sdi2), .sdo(sdo2),
        .err_flag_i(ef2)
    );

    // Slave models: reset on an sck edge with cs_n high; edges 2..6 address, 7 read, 8..23 data.
    int j4 = 0, j2 = 0;
    logic [4:0] sa4 = '0, sa2 = '0;
    logic [15:0] w4 = '0, w2 = '0;

    always @(posedge sck4) begin
        if (cs_n4) begin
            j4 = 0; sdo4 = 1'b0; ef4 = 1'b0;
        end else begin
            j4 = j4 + 1;
            if (j4 >= 2 && j4 <= 6) sa4 = {sa4[3:0], sdi4};
            if (j4 == 7) begin w4 = mem[sa4]; ef4 = alarm; end
            sdo4 = (j4 >= 8 && j4 <= 23) ? w4[23 - j4] : 1'b0;
        end
    end

    always @(posedge sck2) begin
        if (cs_n2) begin
            j2 = 0; sdo2 = 1'b0; ef2 = 1'b0;
        end else begin
            j2 = j2 + 1;
            if (j2 >= 2 && j2 <= 6) sa2 = {sa2[3:0], sdi2};
            if (j2 == 7) begin w2 = mem[sa2]; ef2 = alarm; end
            sdo2 = (j2 >= 8 && j2 <= 23) ? w2[23 - j2] : 1'b0;
        end
    end

    // Runs one read on the selected DUT and measures it. n = clk edges since the accept edge.
    // Optional: pulse start with another address after rising edge glitch_at (DUT4 only),
    // or return right after rising edge abort_at (done_at = -2).
    task automatic do_txn(input bit sel, input logic [4:0] a, input int glitch_at,
                          input int abort_at, output int done_at, output logic [15:0] d,
                          output logic e, output int r_hi, output int r_lo, output int bad_w,
                          output int bad_busy, output logic [4:0] sbits);
        int n, run, lim, dv;
        logic ps, s_sck, s_cs, s_busy, s_done;
        bit glitch_on, fin;
        dv = sel ? D2 : D4;
        lim = 60 * dv;
        done_at = -1; d = 'x; e = 1'bx; r_hi = 0; r_lo = 0; bad_w = 0; bad_busy = 0;
        sbits = '0; ps = 1'b0; run = 0; glitch_on = 1'b0; fin = 1'b0; n = 0;
        @(negedge clk);
        if (sel) begin start2 = 1'b1; addr2 = a; end
        else begin start4 = 1'b1; addr4 = a; end
        @(posedge clk); #1;
        start2 = 1'b0; start4 = 1'b0;
        while (!fin && n < lim) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (glitch_on) begin start4 = 1'b0; addr4 = a; glitch_on = 1'b0; end
            s_sck  = sel ? sck2 : sck4;
            s_cs   = sel ? cs_n2 : cs_n4;
            s_busy = sel ? busy2 : busy4;
            s_done = sel ? done2 : done4;
            if (s_busy !== 1'b1) bad_busy++;
            if (s_sck !== ps) begin
                if (ps && run != dv) bad_w++;
                if (s_sck) begin
                    if (s_cs) r_hi++;
                    else begin
                        r_lo++;
                        if (r_lo >= 2 && run != dv) bad_w++;
                        if (r_lo >= 2 && r_lo <= 6) sbits[6 - r_lo] = sel ? sdi2 : sdi4;
                        if (glitch_at > 0 && r_lo == glitch_at && !sel) begin
                            start4 = 1'b1; addr4 = ~a; glitch_on = 1'b1;
                        end
                        if (abort_at > 0 && r_lo == abort_at) begin
                            done_at = -2; fin = 1'b1;
                        end
                    end
                end
                run = 1;
            end else begin
                run++;
            end
            ps = s_sck;
            if (s_done === 1'b1 && !fin) begin
                done_at = n;
                d = sel ? data2 : data4;
                e = sel ? err2 : err4;
                fin = 1'b1;
                @(posedge clk); #1;
                if ((sel ? busy2 : busy4) !== 1'b0 || (sel ? done2 : done4) !== 1'b0) bad_busy++;
            end
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({sck4, cs_n4, sdi4, busy4, done4, err4, data4} !== {6'b010000, 16'h0000}) begin
            errs++;
            $display("FAIL reset_d4: got %b want %b", {sck4, cs_n4, sdi4, busy4, done4, err4, data4},
                     {6'b010000, 16'h0000});
        end
        vecs++;
        if ({sck2, cs_n2, sdi2, busy2, done2, err2, data2} !== {6'b010000, 16'h0000}) begin
            errs++;
            $display("FAIL reset_d2: got %b want %b", {sck2, cs_n2, sdi2, busy2, done2, err2, data2},
                     {6'b010000, 16'h0000});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_fixed_reads();
        int t, rh, rl, bw, bb;
        logic [15:0] d;
        logic e;
        logic [4:0] sb;
        mem[5] = 16'hA5C3; alarm = 1'b0;
        do_txn(1'b0, 5'd5, 0, 0, t, d, e, rh, rl, bw, bb, sb);
        vecs++; if (t !== 52 * D4) begin errs++; $display("FAIL rd5_done_edge: got %0d want %0d", t, 52 * D4); end
        vecs++; if (d !== 16'hA5C3) begin errs++; $display("FAIL rd5_data: got %h want a5c3", d); end
        vecs++; if (e !== 1'b0) begin errs++; $display("FAIL rd5_err: got %b want 0", e); end
        vecs++; if (sb !== 5'b00101) begin errs++; $display("FAIL rd5_sdi_bits: got %b want 00101", sb); end
        vecs++; if (rh !== 1 || rl !== 24) begin errs++; $display("FAIL rd5_edges: got %0d/%0d want 1/24", rh, rl); end
        vecs++; if (bw !== 0 || bb !== 0) begin errs++; $display("FAIL rd5_phase_busy: got %0d/%0d want 0/0", bw, bb); end

        mem[31] = 16'h8001; alarm = 1'b1;
        do_txn(1'b0, 5'd31, 0, 0, t, d, e, rh, rl, bw, bb, sb);
        vecs++; if (d !== 16'h8001) begin errs++; $display("FAIL rd31_data: got %h want 8001", d); end
        vecs++; if (e !== 1'b1) begin errs++; $display("FAIL rd31_err: got %b want 1", e); end

        mem[0] = 16'h0000; alarm = 1'b0;
        do_txn(1'b0, 5'd0, 0, 0, t, d, e, rh, rl, bw, bb, sb);
        vecs++; if (d !== 16'h0000) begin errs++; $display("FAIL rd0_data: got %h want 0000", d); end
        vecs++; if (e !== 1'b0) begin errs++; $display("FAIL rd0_err: got %b want 0", e); end
    endtask

    task automatic test_random_reads();
        int t, rh, rl, bw, bb;
        logic [15:0] d, w;
        logic e;
        logic [4:0] sb, a;
        for (int i = 0; i < 6; i++) begin
            a = 5'($urandom_range(0, 31));
            w = 16'($urandom);
            mem[a] = w;
            alarm = 1'($urandom);
            do_txn(1'b0, a, 0, 0, t, d, e, rh, rl, bw, bb, sb);
            vecs++;
            if (d !== w || e !== alarm || t !== 52 * D4 || sb !== a) begin
                errs++;
                $display("FAIL rand_rd%0d: got d=%h e=%b t=%0d a=%h want d=%h e=%b t=%0d a=%h",
                         i, d, e, t, sb, w, alarm, 52 * D4, a);
            end
        end
        // Outputs must hold between done pulses.
        repeat (25) @(posedge clk);
        #1;
        vecs++;
        if (data4 !== w || err4 !== alarm) begin
            errs++;
            $display("FAIL hold_stable: got %h/%b want %h/%b", data4, err4, w, alarm);
        end
    endtask

    task automatic test_ignore_start();
        int t, rh, rl, bw, bb, extra;
        logic [15:0] d;
        logic e;
        logic [4:0] sb;
        mem[9] = 16'h1234; mem[22] = 16'hBEEF; alarm = 1'b0;
        do_txn(1'b0, 5'd9, 10, 0, t, d, e, rh, rl, bw, bb, sb);
        vecs++; if (d !== 16'h1234) begin errs++; $display("FAIL ign_data: got %h want 1234", d); end
        vecs++; if (t !== 52 * D4) begin errs++; $display("FAIL ign_done_edge: got %0d want %0d", t, 52 * D4); end
        extra = 0;
        for (int i = 0; i < 60 * D4; i++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1 || busy4 === 1'b1) extra++;
        end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL ign_no_second: got %0d busy cycles want 0", extra); end
    endtask

    task automatic test_abort();
        int t, rh, rl, bw, bb;
        logic [15:0] d;
        logic e;
        logic [4:0] sb;
        mem[5] = 16'hA5C3; alarm = 1'b0;
        do_txn(1'b0, 5'd5, 0, 12, t, d, e, rh, rl, bw, bb, sb);
        vecs++; if (t !== -2) begin errs++; $display("FAIL abort_reach_k12: got %0d want -2", t); end
        rst = 1'b1;
        @(posedge clk); #1;
        vecs++;
        if ({cs_n4, sck4, busy4, done4, sdi4, data4} !== {5'b10000, 16'h0000}) begin
            errs++;
            $display("FAIL abort_state: got %b want %b", {cs_n4, sck4, busy4, done4, sdi4, data4},
                     {5'b10000, 16'h0000});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        do_txn(1'b0, 5'd5, 0, 0, t, d, e, rh, rl, bw, bb, sb);
        vecs++; if (d !== 16'hA5C3) begin errs++; $display("FAIL abort_reread: got %h want a5c3", d); end
    endtask

    task automatic test_div2();
        int t, rh, rl, bw, bb;
        logic [15:0] d, w;
        logic e;
        logic [4:0] sb, a;
        a = 5'($urandom_range(0, 31));
        w = 16'($urandom);
        mem[a] = w; alarm = 1'b0;
        do_txn(1'b1, a, 0, 0, t, d, e, rh, rl, bw, bb, sb);
        vecs++; if (t !== 52 * D2) begin errs++; $display("FAIL d2_done_edge: got %0d want %0d", t, 52 * D2); end
        vecs++; if (rh !== 1 || rl !== 24) begin errs++; $display("FAIL d2_edges: got %0d/%0d want 1/24", rh, rl); end
        vecs++; if (bw !== 0 || bb !== 0) begin errs++; $display("FAIL d2_phase_busy: got %0d/%0d want 0/0", bw, bb); end
        vecs++; if (d !== w || sb !== a) begin errs++; $display("FAIL d2_data: got %h/%h want %h/%h", d, sb, w, a); end
    endtask

    task automatic test_back_to_back();
        int n, ndone, flush, t1, t2;
        logic [15:0] d1, d2;
        logic ps, cs1;
        mem[3] = 16'h3C3C; mem[4] = 16'hC4C4; alarm = 1'b0;
        n = 0; ndone = 0; flush = 0; t1 = -1; t2 = -1; ps = 1'b0; cs1 = 1'b0;
        d1 = 'x; d2 = 'x;
        @(negedge clk);
        start4 = 1'b1; addr4 = 5'd3;
        @(posedge clk); #1;
        addr4 = 5'd4;
        while (ndone < 2 && n < 3 * 60 * D4) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (sck4 && !ps && cs_n4) flush++;
            ps = sck4;
            if (done4 === 1'b1) begin
                if (ndone == 0) begin t1 = n; d1 = data4; cs1 = cs_n4; end
                else begin t2 = n; d2 = data4; start4 = 1'b0; end
                ndone++;
            end
            n++;
        end
        start4 = 1'b0;
        vecs++; if (t1 !== 52 * D4) begin errs++; $display("FAIL b2b_first_edge: got %0d want %0d", t1, 52 * D4); end
        vecs++; if (t2 - t1 !== 52 * D4 + 2) begin errs++; $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, 52 * D4 + 2); end
        vecs++; if (d1 !== 16'h3C3C || d2 !== 16'hC4C4) begin errs++; $display("FAIL b2b_data: got %h/%h want 3c3c/c4c4", d1, d2); end
        vecs++; if (flush !== 2 || cs1 !== 1'b1) begin errs++; $display("FAIL b2b_flush: got %0d/%b want 2/1", flush, cs1); end
        repeat (10) @(posedge clk);
        #1;
        vecs++; if (busy4 !== 1'b0) begin errs++; $display("FAIL b2b_stops: got busy %b want 0", busy4); end
    endtask

    initial begin
        test_reset();
        test_fixed_reads();
        test_random_reads();
        test_ignore_start();
        test_abort();
        test_div2();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
